// File: rtl/rs_alu_scheduler.sv
// Reservation station for the integer ALU: buffers dispatched ops, snoops the
// ALU and LSB CDBs for pending operands, and issues one ready op per cycle.
module rs_alu_scheduler #(
  parameter int RS_SIZE = 16,
  parameter int ROB_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clr,
  input  logic             DEC_sgn,
  input  logic [5:0]       DEC_opcode,
  input  logic [ROB_W-1:0] DEC_ROB_name,
  input  logic [31:0]      DEC_Vj,
  input  logic [31:0]      DEC_Vk,
  input  logic             DEC_Rj,
  input  logic             DEC_Rk,
  input  logic [ROB_W-1:0] DEC_Qj,
  input  logic [ROB_W-1:0] DEC_Qk,
  input  logic             ALU_CDB_sgn,
  input  logic [ROB_W-1:0] ALU_CDB_ROB_name,
  input  logic [31:0]      ALU_CDB_result,
  input  logic             LSB_CDB_sgn,
  input  logic [ROB_W-1:0] LSB_CDB_ROB_name,
  input  logic [31:0]      LSB_CDB_result,
  output logic             full,
  output logic             ALU_sgn,
  output logic [5:0]       ALU_opcode,
  output logic [ROB_W-1:0] ALU_ROB_name,
  output logic [31:0]      ALU_lhs,
  output logic [31:0]      ALU_rhs
);
  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;

  logic [RS_SIZE-1:0] busy_reg;
  logic [RS_SIZE-1:0] rj_reg;
  logic [RS_SIZE-1:0] rk_reg;
  logic [5:0]         opcode_reg [RS_SIZE];
  logic [ROB_W-1:0]   rob_reg    [RS_SIZE];
  logic [31:0]        vj_reg     [RS_SIZE];
  logic [31:0]        vk_reg     [RS_SIZE];
  logic [ROB_W-1:0]   qj_reg     [RS_SIZE];
  logic [ROB_W-1:0]   qk_reg     [RS_SIZE];

  logic [RS_SIZE-1:0] wake_j;
  logic [RS_SIZE-1:0] wake_k;
  logic [RS_SIZE-1:0] ready;
  logic [31:0]        wake_vj [RS_SIZE];
  logic [31:0]        wake_vk [RS_SIZE];

  // ALU CDB takes precedence over LSB CDB when selecting the captured value
  for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_entry
    logic alu_j, lsb_j, alu_k, lsb_k;
    assign alu_j = ALU_CDB_sgn && (ALU_CDB_ROB_name == qj_reg[gi]);
    assign lsb_j = LSB_CDB_sgn && (LSB_CDB_ROB_name == qj_reg[gi]);
    assign alu_k = ALU_CDB_sgn && (ALU_CDB_ROB_name == qk_reg[gi]);
    assign lsb_k = LSB_CDB_sgn && (LSB_CDB_ROB_name == qk_reg[gi]);
    assign wake_j[gi]  = busy_reg[gi] && rj_reg[gi] && (alu_j || lsb_j);
    assign wake_k[gi]  = busy_reg[gi] && rk_reg[gi] && (alu_k || lsb_k);
    assign wake_vj[gi] = alu_j ? ALU_CDB_result : LSB_CDB_result;
    assign wake_vk[gi] = alu_k ? ALU_CDB_result : LSB_CDB_result;
    assign ready[gi]   = busy_reg[gi] && !rj_reg[gi] && !rk_reg[gi];
  end

  // Same-cycle forwarding into the entry being dispatched
  logic        dec_alu_j, dec_lsb_j, dec_alu_k, dec_lsb_k;
  logic        dis_rj, dis_rk;
  logic [31:0] dis_vj, dis_vk;
  assign dec_alu_j = ALU_CDB_sgn && (ALU_CDB_ROB_name == DEC_Qj);
  assign dec_lsb_j = LSB_CDB_sgn && (LSB_CDB_ROB_name == DEC_Qj);
  assign dec_alu_k = ALU_CDB_sgn && (ALU_CDB_ROB_name == DEC_Qk);
  assign dec_lsb_k = LSB_CDB_sgn && (LSB_CDB_ROB_name == DEC_Qk);
  assign dis_rj = DEC_Rj && !(dec_alu_j || dec_lsb_j);
  assign dis_rk = DEC_Rk && !(dec_alu_k || dec_lsb_k);
  assign dis_vj = !DEC_Rj ? DEC_Vj : dec_alu_j ? ALU_CDB_result :
                  dec_lsb_j ? LSB_CDB_result : DEC_Vj;
  assign dis_vk = !DEC_Rk ? DEC_Vk : dec_alu_k ? ALU_CDB_result :
                  dec_lsb_k ? LSB_CDB_result : DEC_Vk;

  logic               free_found, issue_found, do_dispatch, full_next;
  logic [IDX_W-1:0]   free_idx, issue_idx;
  logic [RS_SIZE-1:0] busy_next;
  logic [CNT_W-1:0]   busy_cnt;

  // Descending scan so the lowest index wins for both allocation and issue
  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    issue_found = 1'b0;
    issue_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_reg[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (ready[i]) begin
        issue_found = 1'b1;
        issue_idx   = IDX_W'(i);
      end
    end
  end

  assign do_dispatch = DEC_sgn && !full && free_found;

  always_comb begin
    busy_next = busy_reg;
    if (issue_found) busy_next[issue_idx] = 1'b0;
    if (do_dispatch) busy_next[free_idx] = 1'b1;
    busy_cnt = '0;
    for (int i = 0; i < RS_SIZE; i++) busy_cnt = busy_cnt + CNT_W'(busy_next[i]);
  end

  assign full_next = (busy_cnt == CNT_W'(RS_SIZE));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg     <= '0;
      full         <= 1'b0;
      ALU_sgn      <= 1'b0;
      ALU_opcode   <= '0;
      ALU_ROB_name <= '0;
      ALU_lhs      <= '0;
      ALU_rhs      <= '0;
    end else if (clr) begin
      busy_reg <= '0;
      full     <= 1'b0;
      ALU_sgn  <= 1'b0;
    end else if (rdy) begin
      busy_reg <= busy_next;
      full     <= full_next;
      ALU_sgn  <= issue_found;
      if (issue_found) begin
        ALU_opcode   <= opcode_reg[issue_idx];
        ALU_ROB_name <= rob_reg[issue_idx];
        ALU_lhs      <= vj_reg[issue_idx];
        ALU_rhs      <= vk_reg[issue_idx];
      end
      for (int i = 0; i < RS_SIZE; i++) begin
        if (wake_j[i]) begin
          vj_reg[i] <= wake_vj[i];
          rj_reg[i] <= 1'b0;
        end
        if (wake_k[i]) begin
          vk_reg[i] <= wake_vk[i];
          rk_reg[i] <= 1'b0;
        end
      end
      if (do_dispatch) begin
        opcode_reg[free_idx] <= DEC_opcode;
        rob_reg[free_idx]    <= DEC_ROB_name;
        vj_reg[free_idx]     <= dis_vj;
        vk_reg[free_idx]     <= dis_vk;
        rj_reg[free_idx]     <= dis_rj;
        rk_reg[free_idx]     <= dis_rk;
        qj_reg[free_idx]     <= DEC_Qj;
        qk_reg[free_idx]     <= DEC_Qk;
      end
    end else begin
      ALU_sgn <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rs_alu_scheduler.sv
// Scoreboard bench for rs_alu_scheduler: a reference model predicts issues and
// the full flag; a negedge monitor compares them against the DUT.
module tb_rs_alu_scheduler;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst, rdy, clr;
  logic        dec_sgn, dec_rj, dec_rk;
  logic [5:0]  dec_op;
  logic [3:0]  dec_tag, dec_qj, dec_qk;
  logic [31:0] dec_vj, dec_vk;
  logic        acdb_sgn, lcdb_sgn;
  logic [3:0]  acdb_tag, lcdb_tag;
  logic [31:0] acdb_res, lcdb_res;
  logic        full, alu_sgn;
  logic [5:0]  alu_op;
  logic [3:0]  alu_tag;
  logic [31:0] alu_lhs, alu_rhs;

  always #5 clk = ~clk;

  rs_alu_scheduler #(.RS_SIZE(N), .ROB_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .DEC_sgn(dec_sgn), .DEC_opcode(dec_op), .DEC_ROB_name(dec_tag),
    .DEC_Vj(dec_vj), .DEC_Vk(dec_vk), .DEC_Rj(dec_rj), .DEC_Rk(dec_rk),
    .DEC_Qj(dec_qj), .DEC_Qk(dec_qk),
    .ALU_CDB_sgn(acdb_sgn), .ALU_CDB_ROB_name(acdb_tag), .ALU_CDB_result(acdb_res),
    .LSB_CDB_sgn(lcdb_sgn), .LSB_CDB_ROB_name(lcdb_tag), .LSB_CDB_result(lcdb_res),
    .full(full), .ALU_sgn(alu_sgn), .ALU_opcode(alu_op), .ALU_ROB_name(alu_tag),
    .ALU_lhs(alu_lhs), .ALU_rhs(alu_rhs)
  );

  typedef struct {
    bit v; logic [5:0] op; logic [3:0] tag;
    logic [31:0] vj, vk; bit rj, rk; logic [3:0] qj, qk;
  } ent_t;
  typedef struct {
    int cyc; logic [5:0] op; logic [3:0] tag; logic [31:0] lhs, rhs;
  } iss_t;

  ent_t        m [N];
  iss_t        sb [$];
  bit          exp_full;
  logic [5:0]  last_op;
  logic [3:0]  last_tag;
  logic [31:0] last_lhs, last_rhs;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  bit          chk_en = 0;

  function automatic bit snoop(input logic [3:0] q, output logic [31:0] val);
    val = 32'd0;
    if (acdb_sgn && acdb_tag == q) begin val = acdb_res; return 1'b1; end
    if (lcdb_sgn && lcdb_tag == q) begin val = lcdb_res; return 1'b1; end
    return 1'b0;
  endfunction

  // Reference model: applies one clock edge's worth of behaviour to m[]
  task automatic model_update();
    int sel = -1, slot = -1, cnt = 0;
    logic [31:0] val;
    iss_t e;
    if (rst) begin
      foreach (m[i]) m[i].v = 0;
      exp_full = 0; last_op = '0; last_tag = '0; last_lhs = '0; last_rhs = '0;
      return;
    end
    if (clr) begin
      foreach (m[i]) m[i].v = 0;
      exp_full = 0;
      return;
    end
    if (!rdy) return;
    for (int i = 0; i < N; i++) begin
      if (sel < 0 && m[i].v && !m[i].rj && !m[i].rk) sel = i;
      if (slot < 0 && !m[i].v) slot = i;
    end
    if (sel >= 0) begin
      e.cyc = cyc + 1; e.op = m[sel].op; e.tag = m[sel].tag;
      e.lhs = m[sel].vj; e.rhs = m[sel].vk;
      sb.push_back(e);
      last_op = e.op; last_tag = e.tag; last_lhs = e.lhs; last_rhs = e.rhs;
      m[sel].v = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (m[i].v && m[i].rj && snoop(m[i].qj, val)) begin m[i].vj = val; m[i].rj = 0; end
      if (m[i].v && m[i].rk && snoop(m[i].qk, val)) begin m[i].vk = val; m[i].rk = 0; end
    end
    if (dec_sgn && !exp_full && slot >= 0) begin
      m[slot].v = 1; m[slot].op = dec_op; m[slot].tag = dec_tag;
      m[slot].vj = dec_vj; m[slot].rj = dec_rj; m[slot].qj = dec_qj;
      m[slot].vk = dec_vk; m[slot].rk = dec_rk; m[slot].qk = dec_qk;
      if (dec_rj && snoop(dec_qj, val)) begin m[slot].vj = val; m[slot].rj = 0; end
      if (dec_rk && snoop(dec_qk, val)) begin m[slot].vk = val; m[slot].rk = 0; end
    end
    foreach (m[i]) if (m[i].v) cnt++;
    exp_full = (cnt == N);
  endtask

  // Monitor: one line per compared transaction
  always @(negedge clk) begin
    if (chk_en) begin
      iss_t e;
      if (alu_sgn) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL issue_spurious cyc=%0d got tag=%0d lhs=%h rhs=%h, none expected",
                   cyc, alu_tag, alu_lhs, alu_rhs);
        end else begin
          e = sb.pop_front();
          if (e.cyc != cyc || alu_op !== e.op || alu_tag !== e.tag ||
              alu_lhs !== e.lhs || alu_rhs !== e.rhs) begin
            n_bad++;
            $display("FAIL issue cyc=%0d got op=%h tag=%0d lhs=%h rhs=%h, want cyc=%0d op=%h tag=%0d lhs=%h rhs=%h",
                     cyc, alu_op, alu_tag, alu_lhs, alu_rhs, e.cyc, e.op, e.tag, e.lhs, e.rhs);
          end else
            $display("cyc=%0d issue op=%h tag=%0d lhs=%h rhs=%h ok", cyc, alu_op, alu_tag, alu_lhs, alu_rhs);
        end
      end else begin
        n_vec++;
        if (sb.size() != 0 && sb[0].cyc <= cyc) begin
          e = sb.pop_front();
          n_bad++;
          $display("FAIL issue_missing cyc=%0d got ALU_sgn=0, want tag=%0d lhs=%h rhs=%h",
                   cyc, e.tag, e.lhs, e.rhs);
        end else if (alu_op !== last_op || alu_tag !== last_tag ||
                     alu_lhs !== last_lhs || alu_rhs !== last_rhs) begin
          n_bad++;
          $display("FAIL hold cyc=%0d got op=%h tag=%0d lhs=%h rhs=%h, want op=%h tag=%0d lhs=%h rhs=%h",
                   cyc, alu_op, alu_tag, alu_lhs, alu_rhs, last_op, last_tag, last_lhs, last_rhs);
        end
      end
      n_vec++;
      if (full !== exp_full) begin
        n_bad++;
        $display("FAIL full cyc=%0d got %b want %b", cyc, full, exp_full);
      end
    end
  end

  task automatic tick();
    model_update();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    #1;
  endtask

  task automatic set_idle();
    dec_sgn = 0; dec_op = '0; dec_tag = '0; dec_vj = '0; dec_vk = '0;
    dec_rj = 0; dec_rk = 0; dec_qj = '0; dec_qk = '0;
    acdb_sgn = 0; acdb_tag = '0; acdb_res = '0;
    lcdb_sgn = 0; lcdb_tag = '0; lcdb_res = '0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [3:0] tag,
                      input logic [31:0] vj, input bit rj, input logic [3:0] qj,
                      input logic [31:0] vk, input bit rk, input logic [3:0] qk);
    dec_sgn = 1; dec_op = op; dec_tag = tag;
    dec_vj = vj; dec_rj = rj; dec_qj = qj;
    dec_vk = vk; dec_rk = rk; dec_qk = qk;
  endtask

  task automatic idle(input int n);
    set_idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    set_idle();
    rdy = 1; clr = 0; rst = 1;
    tick();
    chk_en = 1;
    tick();
    rst = 0;
    idle(2);

    // Ready ADD: issues after the next edge
    disp(6'h01, 4'd3, 32'd5, 0, 4'd0, 32'd7, 0, 4'd0); tick();
    idle(3);

    // SUB waiting on tag 6, woken by ALU CDB
    disp(6'h02, 4'd4, 32'd0, 1, 4'd6, 32'd1, 0, 4'd0); tick();
    idle(3);
    acdb_sgn = 1; acdb_tag = 4'd6; acdb_res = 32'h10; tick();
    idle(3);

    // Dispatch-time capture from LSB CDB
    disp(6'h03, 4'd5, 32'd9, 0, 4'd0, 32'd0, 1, 4'd2);
    lcdb_sgn = 1; lcdb_tag = 4'd2; lcdb_res = 32'hFFFF_FFFF; tick();
    idle(3);

    // Fill all entries on tag 9, then a dropped 17th dispatch
    for (int i = 0; i < N + 1; i++) begin
      disp(6'(i + 8), 4'(i), 32'd0, 1, 4'd9, 32'(i * 3), 0, 4'd0); tick();
    end
    set_idle();
    acdb_sgn = 1; acdb_tag = 4'd9; acdb_res = 32'hCAFE_0009; tick();
    idle(N + 3);

    // Flush with a ready entry and a simultaneous dispatch
    for (int i = 0; i < 3; i++) begin
      disp(6'h20, 4'(i + 1), 32'd1, 1, 4'd12, 32'd2, 0, 4'd0); tick();
    end
    disp(6'h21, 4'd7, 32'd11, 0, 4'd0, 32'd22, 0, 4'd0); tick();
    disp(6'h22, 4'd8, 32'd33, 0, 4'd0, 32'd44, 0, 4'd0); clr = 1; tick();
    clr = 0;
    idle(2);
    acdb_sgn = 1; acdb_tag = 4'd12; acdb_res = 32'h1212; tick();
    idle(3);

    // Stall while a ready op is waiting
    disp(6'h30, 4'd10, 32'hA, 0, 4'd0, 32'hB, 0, 4'd0); tick();
    set_idle(); rdy = 0;
    tick(); tick(); tick();
    rdy = 1;
    idle(3);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(9, 0) != 0);
      clr = ($urandom_range(39, 0) == 0);
      dec_sgn = ($urandom_range(2, 0) != 0);
      dec_op = 6'($urandom_range(63, 0));
      dec_tag = 4'($urandom_range(15, 0));
      dec_vj = $urandom; dec_vk = $urandom;
      dec_rj = ($urandom_range(1, 0) == 1);
      dec_rk = ($urandom_range(2, 0) == 0);
      dec_qj = 4'($urandom_range(15, 0));
      dec_qk = 4'($urandom_range(15, 0));
      acdb_sgn = ($urandom_range(1, 0) == 1);
      acdb_tag = 4'($urandom_range(15, 0));
      acdb_res = $urandom;
      lcdb_sgn = ($urandom_range(2, 0) == 0);
      lcdb_tag = 4'($urandom_range(15, 0));
      if (acdb_sgn && lcdb_sgn && lcdb_tag == acdb_tag) lcdb_tag = acdb_tag + 4'd1;
      lcdb_res = $urandom;
      tick();
    end
    clr = 0; rdy = 1;
    idle(4);

    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d outstanding issues want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
